// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
// Imported by the unit, its division step, and the bench.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } MdOp_t;

    localparam int MD_ITERS = 32;

    // State names carry an S_ prefix so they do not collide with the DIV operation.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } MdState_t;

    function automatic logic is_signed_op(input MdOp_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module md_div_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem, dividend_bit};
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the modular difference are exact.
    assign diff     = shifted[WIDTH-1:0] - divisor;
    assign q_bit    = shifted >= {1'b0, divisor};
    assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32 shift-add or restoring-division
// iterations followed by one sign-correction cycle that writes HI/LO atomically.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       optr,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    MdState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;
    logic             is_div;
    logic             div_zero;

    MdOp_t            op;
    logic             accept;
    logic             sgn_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign op     = MdOp_t'(optr);
    assign busy   = (state != S_IDLE);
    assign accept = start && !flush && (state == S_IDLE);
    assign sgn_op = is_signed_op(op);
    assign mag_a  = (sgn_op && opA[WIDTH-1]) ? -opA : opA;
    assign mag_b  = (sgn_op && opB[WIDTH-1]) ? -opB : opB;

    // Multiply: acc_hi holds the running upper half, acc_lo the multiplier being shifted out.
    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc_hi),
        .divisor      (opnd),
        .dividend_bit (acc_lo[WIDTH-1]),
        .rem_next     (div_rem),
        .q_bit        (div_q)
    );

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        fix_hi   = acc_hi;
        fix_lo   = acc_lo;
        if (is_div) begin
            fix_lo = div_zero ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
            fix_hi = neg_r ? -acc_hi : acc_hi;
        end else begin
            if (neg_q) prod_fix = -{acc_hi, acc_lo};
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && flush) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            case (op)
                                MTHI: hi <= opA;
                                MTLO: lo <= opA;
                                MULT, MULTU: begin
                                    state    <= S_MUL;
                                    cnt      <= '0;
                                    acc_hi   <= '0;
                                    acc_lo   <= mag_b;
                                    opnd     <= mag_a;
                                    neg_q    <= sgn_op && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                                    neg_r    <= 1'b0;
                                    is_div   <= 1'b0;
                                    div_zero <= 1'b0;
                                end
                                DIV, DIVU: begin
                                    state    <= S_DIV;
                                    cnt      <= '0;
                                    acc_hi   <= '0;
                                    acc_lo   <= mag_a;
                                    opnd     <= mag_b;
                                    neg_q    <= sgn_op && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                                    neg_r    <= sgn_op && opA[WIDTH-1];
                                    is_div   <= 1'b1;
                                    div_zero <= (opB == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIXUP;
                    end
                    S_DIV: begin
                        acc_hi <= div_rem;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_q};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table-driven and random MULT/DIV vectors
// checked through a scoreboard, plus flush, reset and issue corner sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  optr = 3'd0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    int start_while_busy = 0;
    logic [63:0] sb[$];

    typedef struct {
        MdOp_t       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .optr  (optr),
        .opA   (opA),
        .opB   (opB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference built on 64-bit signed arithmetic.
    function automatic logic [63:0] ref_model(input MdOp_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            MULT: begin
                p = 64'(sa * sb_);
                return p;
            end
            MULTU: return {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result", {hi, lo}, sb.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && start && busy) start_while_busy++;
    end

    task automatic issue(input MdOp_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        optr  = op;
        opA   = a;
        opB   = b;
        @(negedge clk);
        start = 1'b0;
        optr  = NONE;
    endtask

    task automatic run_op(input MdOp_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int n;
        sb.push_back(exp);
        issue(op, a, b);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(MD_ITERS + 1));
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_once", 64'(done), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        MdOp_t rop;
        logic [31:0] ra, rb;
        int n;
        int done_seen;

        vecs.push_back('{MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA});
        vecs.push_back('{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{DIVU,  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003});
        vecs.push_back('{DIV,   32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF});
        vecs.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        vecs.push_back('{DIVU,  32'h89AB_CDEF, 32'h0000_0000, 64'h89AB_CDEF_FFFF_FFFF});
        vecs.push_back('{DIV,   32'h8000_0000, 32'h0000_0000, 64'h8000_0000_FFFF_FFFF});
        vecs.push_back('{MULT,  32'h0000_0007, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD});
        vecs.push_back('{DIV,   32'h0000_0064, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2});
        vecs.push_back('{DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF});
        vecs.push_back('{MULTU, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780});

        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            rop = MdOp_t'(3'($urandom_range(1, 4)));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            run_op(rop, ra, rb, ref_model(rop, ra, rb));
        end

        // MTHI writes immediately without raising busy.
        issue(MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        check("mthi_busy", 64'(busy), 64'd0);

        // Flush mid-multiply leaves HI/LO untouched and produces no done.
        issue(MTHI, 32'd5, 32'd0);
        issue(MTLO, 32'd5, 32'd0);
        issue(MULT, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, {32'd5, 32'd5});
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);

        // Flush during the FIXUP cycle suppresses the write.
        issue(MULTU, 32'd9, 32'd9);
        repeat (32) @(negedge clk);
        check("fixup_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixup_flush_busy", 64'(busy), 64'd0);
        check("fixup_flush_hilo", {hi, lo}, {32'd5, 32'd5});

        // Reset mid-operation clears HI/LO at once.
        issue(MULT, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A start while busy is ignored; the original result lands unchanged.
        sb.push_back({32'd2, 32'd14});
        issue(DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        optr  = MULTU;
        opA   = 32'd1;
        opB   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        optr  = NONE;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_ignore_len", 64'(n), 64'(MD_ITERS - 3));
        @(negedge clk);
        check("busy_ignore_idle", 64'(busy), 64'd0);
        check("busy_ignore_hilo", {hi, lo}, {32'd2, 32'd14});

        // start together with flush in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        optr  = MTHI;
        opA   = 32'h1111_1111;
        @(negedge clk);
        optr  = MULT;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        optr  = NONE;
        check("sf_busy", 64'(busy), 64'd0);
        check("sf_hi", 64'(hi), 64'd2);

        repeat (3) @(negedge clk);
        check("start_while_busy_flags", 64'(start_while_busy), 64'd1);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
